dst_stream_ctrl: RTL and testbench
==================================

Name:
dst_stream_ctrl

Overview:
Parametrised destination-stream controller, successor to the fixed 8-beat destination sequencer. On each upstream finish pulse (s_fin_in) it emits one burst of LEN address beats toward the destination buffer, stalling on dst_ready. Triggers that arrive during a burst are queued and served back-to-back. Sits between the compute-finish logic and the destination write port.

Parameters:
AW, 3, stream_a width in bits.
LEN, 8, beats per burst; legal range 1..2^16.
BASE, 0, address of beat 0, AW bits.
STRIDE, 1, address increment per beat, AW bits.
PW, 2, pending-trigger counter width; up to 2^PW-1 queued triggers.

Ports:
clk  in  1  system clock.
run  in  1  asynchronous active-low reset; run=0 resets all state.
dst_ready  in  1  destination ready; all stream state advances only when 1.
s_fin_in  in  1  burst trigger, one pulse per burst; sampled every cycle regardless of dst_ready.
dst_valid  out  1  stream_v delayed one ready-cycle; destination-side data-valid.
stream_v  out  1  address beat valid this cycle.
stream_a  out  AW  beat address.
stream_last  out  1  final beat of a burst.
busy  out  1  burst active or trigger pending.
overflow  out  1  sticky; a trigger was lost.

Behaviour:
- Reset (run=0, async): state IDLE, beat index i=0, pend=0, dst_valid=0, overflow=0, bank=0. Outputs therefore stream_v=0, stream_last=0, busy=0, stream_a=BASE.
- Beat index i has width max(1,clog2(LEN)). stream_a = (BASE + i*STRIDE) mod 2^AW, combinational from i.
- trig = s_fin_in | (pend != 0).
- FSM, two states:
  - IDLE: when dst_ready & trig, go to ACTIVE with i=0 and consume one trigger. When dst_ready=0, stay in IDLE; the trigger remains queued.
  - ACTIVE: stream_v = dst_ready. When dst_ready=1 and i<LEN-1, i increments. When dst_ready=1 and i==LEN-1: if trig, stay in ACTIVE, set i=0 and consume a trigger (no bubble between bursts); otherwise go to IDLE with i=0. When dst_ready=0, everything holds.
- stream_last = stream_v & (i==LEN-1). LEN=1 gives stream_last on every beat.
- Latency: s_fin_in=1 at cycle t with dst_ready=1 and state IDLE gives stream_v=1 and stream_a=BASE at t+1.
- dst_valid: register loaded with (state==ACTIVE) on cycles where dst_ready=1; holds otherwise.
- Pending counter:
  - Consume: uses the same-cycle s_fin_in first; otherwise decrements pend.
  - s_fin_in not consumed that cycle: pend+1.
  - Simultaneous s_fin_in and consume-from-pend: pend unchanged.
  - pend == 2^PW-1 and s_fin_in not consumed: pend saturates, the trigger is dropped and overflow=1. overflow clears only on reset.
- busy = (state==ACTIVE) | (pend != 0).
- run deasserted mid-burst: immediate async clear. No partial-burst resume; pending triggers are lost.

Optional Feature:
Macro DST_STREAM_CTRL_BANK_EN.
- Defined: an internal bank bit toggles at every burst end (stream_last accepted). The bit is placed at stream_a[AW-1] and replaces the MSB of the computed address. Bursts therefore ping-pong between the two halves of the destination buffer. The bit resets to 0.
- Not defined: no bank bit; stream_a is the full computed address.

Test Plan:
1. Defaults, dst_ready=1, single s_fin_in pulse at t0 -> stream_v on t0+1..t0+8, stream_a 0..7, stream_last at t0+8, dst_valid on t0+2..t0+9, busy falls at t0+9.
2. dst_ready=0 for cycles 3-5 of a burst -> stream_v=0 and stream_a frozen at 2 during the stall; stream_v and stream_a resume at 2 with no beat lost; dst_valid holds its value.
3. Second s_fin_in pulse mid-burst -> stream_a wraps 7->0 with no idle cycle; 16 consecutive beats; pend goes 1->0.
4. PW=2: five s_fin_in pulses during one burst -> pend saturates at 3, overflow=1; exactly 4 bursts emitted in total.
5. LEN=3, BASE=5, STRIDE=2, AW=3 -> stream_a 5,7,1 (mod-8 wrap); stream_last on the beat with address 1.
6. run=0 pulse at beat 4 with pend=2 -> all outputs 0 within the same cycle; after run=1, no stream activity until a new s_fin_in. With DST_STREAM_CTRL_BANK_EN: consecutive bursts give stream_a 0..3, then 4..7.

Source files
------------

// File: rtl/dst_stream_ctrl.sv
// Destination-stream controller: one burst of LEN address beats per s_fin_in, queued triggers.
// Optional DST_STREAM_CTRL_BANK_EN: bank bit toggled per burst overrides stream_a[AW-1].
module dst_stream_ctrl #(
   parameter int unsigned AW     = 3,
   parameter int unsigned LEN    = 8,
   parameter int unsigned BASE   = 0,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned PW     = 2
) (
   input  logic          clk,
   input  logic          run,
   input  logic          dst_ready,
   input  logic          s_fin_in,
   output logic          dst_valid,
   output logic          stream_v,
   output logic [AW-1:0] stream_a,
   output logic          stream_last,
   output logic          busy,
   output logic          overflow
);

   localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

   localparam logic [0:0]    StIdle   = 1'b0;
   localparam logic [0:0]    StActive = 1'b1;
   localparam logic [IW-1:0] LastIdx  = IW'(LEN - 1);
   localparam logic [PW-1:0] PendMax  = {PW{1'b1}};
   localparam logic [AW-1:0] BaseAw   = AW'(BASE);
   localparam logic [AW-1:0] StrideAw = AW'(STRIDE);

   logic [0:0]    r_state;
   logic [IW-1:0] r_idx;
   logic [PW-1:0] r_pend;
   logic          r_dst_valid;
   logic          r_overflow;

   logic [0:0]    w_state_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic [PW-1:0] w_pend_nxt;
   logic          w_ovf_set;
   logic          w_trig;
   logic          w_active;
   logic          w_at_last;
   logic          w_beat;
   logic          w_consume;
   logic [AW-1:0] w_idx_aw;
   logic [AW-1:0] w_addr;

   assign w_trig    = s_fin_in | (r_pend != '0);
   assign w_active  = (r_state == StActive);
   assign w_at_last = (r_idx == LastIdx);
   assign w_beat    = w_active & dst_ready;
   // A trigger is taken when a burst starts from idle or chains off the final beat.
   assign w_consume = dst_ready & w_trig & (~w_active | w_at_last);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (dst_ready) begin
         if (!w_active) begin
            if (w_trig) begin
               w_state_nxt = StActive;
               w_idx_nxt   = '0;
            end
         end else if (!w_at_last) begin
            w_idx_nxt = r_idx + IW'(1);
         end else begin
            w_idx_nxt   = '0;
            w_state_nxt = w_trig ? StActive : StIdle;
         end
      end
   end

   // Same-cycle s_fin_in is consumed first, so pend only moves when exactly one side acts.
   always_comb begin
      w_pend_nxt = r_pend;
      w_ovf_set  = 1'b0;
      if (w_consume && !s_fin_in) begin
         w_pend_nxt = r_pend - PW'(1);
      end else if (!w_consume && s_fin_in) begin
         if (r_pend == PendMax) begin
            w_ovf_set = 1'b1;
         end else begin
            w_pend_nxt = r_pend + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge run) begin
      if (!run) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_pend      <= '0;
         r_dst_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_pend     <= w_pend_nxt;
         r_overflow <= r_overflow | w_ovf_set;
         if (dst_ready) begin
            r_dst_valid <= w_active;
         end
      end
   end

   assign w_idx_aw = AW'(r_idx);
   assign w_addr   = BaseAw + (w_idx_aw * StrideAw);

`ifdef DST_STREAM_CTRL_BANK_EN
   localparam logic [AW-1:0] MsbMask = AW'(1) << (AW - 1);

   logic r_bank;

   always_ff @(posedge clk or negedge run) begin
      if (!run) begin
         r_bank <= 1'b0;
      end else if (w_beat && w_at_last) begin
         r_bank <= ~r_bank;
      end
   end

   assign stream_a = (w_addr & ~MsbMask) | ({AW{r_bank}} & MsbMask);
`else
   assign stream_a = w_addr;
`endif

   assign stream_v    = w_beat;
   assign stream_last = w_beat & w_at_last;
   assign busy        = w_active | (r_pend != '0);
   assign dst_valid   = r_dst_valid;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_dst_stream_ctrl.sv
// Scoreboard bench for dst_stream_ctrl: default instance plus a LEN=3/BASE=5/STRIDE=2 instance.
module tb_dst_stream_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic run, dst_ready, s_fin_in, fin5;
   logic dv0, sv0, sl0, busy0, ovf0;
   logic dv5, sv5, sl5, busy5, ovf5;
   logic [2:0] sa0, sa5;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt;

   logic [3:0] q0[$];
   logic [3:0] q5[$];
   logic bank0 = 1'b0;
   logic bank5 = 1'b0;

   dst_stream_ctrl dut (
      .clk(clk), .run(run), .dst_ready(dst_ready), .s_fin_in(s_fin_in),
      .dst_valid(dv0), .stream_v(sv0), .stream_a(sa0), .stream_last(sl0),
      .busy(busy0), .overflow(ovf0)
   );

   dst_stream_ctrl #(.AW(3), .LEN(3), .BASE(5), .STRIDE(2), .PW(2)) dut5 (
      .clk(clk), .run(run), .dst_ready(dst_ready), .s_fin_in(fin5),
      .dst_valid(dv5), .stream_v(sv5), .stream_a(sa5), .stream_last(sl5),
      .busy(busy5), .overflow(ovf5)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push n expected beats; a complete burst flips the modelled bank bit.
   task automatic push(input int which, input int n);
      int len, base, stride;
      logic b;
      logic [2:0] a;
      len    = (which != 0) ? 3 : 8;
      base   = (which != 0) ? 5 : 0;
      stride = (which != 0) ? 2 : 1;
      b      = (which != 0) ? bank5 : bank0;
      for (int i = 0; i < n; i++) begin
         a = 3'((base + i * stride) % 8);
`ifdef DST_STREAM_CTRL_BANK_EN
         a[2] = b;
`endif
         if (which != 0) q5.push_back({(i == len - 1), a});
         else            q0.push_back({(i == len - 1), a});
      end
      if (n == len) begin
         if (which != 0) bank5 = ~bank5;
         else            bank0 = ~bank0;
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         if (!busy0 && !busy5) return;
         tick();
      end
      fail("idle timeout");
   endtask

   always @(negedge clk) begin : mon
      logic [3:0] e;
      if (sv0) begin
         if (q0.size() == 0) fail("beat0 unexpected");
         else begin
            e = q0.pop_front();
            check("beat0 addr", 32'(sa0), 32'(e[2:0]));
            check("beat0 last", 32'(sl0), 32'(e[3]));
         end
      end
      if (sv5) begin
         if (q5.size() == 0) fail("beat5 unexpected");
         else begin
            e = q5.pop_front();
            check("beat5 addr", 32'(sa5), 32'(e[2:0]));
            check("beat5 last", 32'(sl5), 32'(e[3]));
         end
      end
   end

   initial begin
      run = 1'b0; dst_ready = 1'b1; s_fin_in = 1'b0; fin5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst stream_v", 32'(sv0), 0);
      check("rst stream_last", 32'(sl0), 0);
      check("rst busy", 32'(busy0), 0);
      check("rst stream_a", 32'(sa0), 0);
      check("rst overflow", 32'(ovf0), 0);
      check("rst dst_valid", 32'(dv0), 0);
      check("rst stream_a5", 32'(sa5), 5);
      run = 1'b1;
      tick(); tick();

      // single burst timing
      s_fin_in = 1'b1; push(0, 8); tick(); s_fin_in = 1'b0;
      check("t1 latency v", 32'(sv0), 1);
      check("t1 latency a", 32'(sa0), 0);
      check("t1 dv first", 32'(dv0), 0);
      check("t1 busy", 32'(busy0), 1);
      repeat (7) tick();
      check("t1 last", 32'(sl0), 1);
      check("t1 dv mid", 32'(dv0), 1);
      tick();
      check("t1 busy fall", 32'(busy0), 0);
      check("t1 dv tail", 32'(dv0), 1);
      check("t1 v off", 32'(sv0), 0);
      tick();
      check("t1 dv off", 32'(dv0), 0);

      // stall on beat address 2
      s_fin_in = 1'b1; push(0, 8); tick(); s_fin_in = 1'b0;
      tick(); tick();
      dst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t2 stall v", 32'(sv0), 0);
         check("t2 stall a", 32'(sa0), 2);
         check("t2 stall dv", 32'(dv0), 1);
         tick();
      end
      dst_ready = 1'b1;
      #1;
      check("t2 resume v", 32'(sv0), 1);
      check("t2 resume a", 32'(sa0), 2);
      wait_idle();

      // back-to-back bursts
      s_fin_in = 1'b1; push(0, 8); tick(); s_fin_in = 1'b0;
      cnt = 0;
      for (int k = 0; k < 18; k++) begin
         if (k == 2) begin
            s_fin_in = 1'b1; push(0, 8);
         end
         #1;
         if (sv0) cnt++;
         tick();
         s_fin_in = 1'b0;
      end
      check("t3 beat count", 32'(cnt), 16);
      check("t3 idle", 32'(busy0), 0);

      // pending saturation
      s_fin_in = 1'b1; push(0, 8); tick(); s_fin_in = 1'b0;
      tick();
      check("t4 ovf before", 32'(ovf0), 0);
      for (int k = 0; k < 5; k++) begin
         s_fin_in = 1'b1; tick(); s_fin_in = 1'b0;
      end
      push(0, 8); push(0, 8); push(0, 8);
      check("t4 ovf set", 32'(ovf0), 1);
      wait_idle();
      check("t4 ovf sticky", 32'(ovf0), 1);

      // odd parameter instance
      fin5 = 1'b1; push(1, 3); tick(); fin5 = 1'b0;
      check("t5 first v", 32'(sv5), 1);
      check("t5 first last", 32'(sl5), 0);
      tick(); tick();
      check("t5 last v", 32'(sv5), 1);
      check("t5 last", 32'(sl5), 1);
      tick();
      check("t5 busy fall", 32'(busy5), 0);

      // reset mid-burst with two pending triggers
      s_fin_in = 1'b1; push(0, 4); tick();
      tick(); tick(); s_fin_in = 1'b0;
      tick(); tick();
      check("t6 pre v", 32'(sv0), 1);
      check("t6 pre busy", 32'(busy0), 1);
      run = 1'b0;
      #1;
      check("t6 rst v", 32'(sv0), 0);
      check("t6 rst last", 32'(sl0), 0);
      check("t6 rst busy", 32'(busy0), 0);
      check("t6 rst dv", 32'(dv0), 0);
      check("t6 rst ovf", 32'(ovf0), 0);
      check("t6 rst a", 32'(sa0), 0);
      bank0 = 1'b0; bank5 = 1'b0;
      tick(); tick();
      run = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (sv0) cnt++;
      end
      check("t6 quiet", 32'(cnt), 0);
      check("t6 quiet busy", 32'(busy0), 0);
      s_fin_in = 1'b1; push(0, 8); tick(); s_fin_in = 1'b0;
      wait_idle();
      tick();

      check("q0 drained", 32'(q0.size()), 0);
      check("q5 drained", 32'(q5.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
